// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback arbiter
package wb_pkg;
   typedef enum logic {ARB_IDLE, ARB_HELD} arb_state_t;
   localparam int WB_CNT_W = 16;
endpackage

// File: rtl/wb_arb_port.sv
// wb_arb_port: one register-file port's arbiter (scalar pipeline vs. vector pipeline with a one-entry buffer)
module wb_arb_port
   import wb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic scalar_req,
   input  logic vector_req,
   output logic wb_sel,
   output logic buffer_sel,
   output logic capture,
   output logic stall
);
   arb_state_t state;
   logic held;
   assign held = (state == ARB_HELD);
   // an entry stays buffered after a conflict in IDLE, or while the vector stream keeps refilling it in HELD
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= ARB_IDLE;
      else state <= (held ? vector_req : (scalar_req & vector_req)) ? ARB_HELD : ARB_IDLE;
   // HELD always drains the buffer; live vector wins in IDLE only when the scalar side is quiet
   always_comb begin
      wb_sel     = rst_n & (held | (vector_req & ~scalar_req));
      buffer_sel = rst_n & held;
      capture    = rst_n & vector_req & (held | scalar_req);
      stall      = rst_n & held & scalar_req;
   end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbitration for the REG and VEC ports; optional capture counter under WB_ARB_STATS_EN
module wb_arbiter
   import wb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic scalar_reg_req,
   input  logic scalar_vec_req,
   input  logic vector_reg_req,
   input  logic vector_vec_req,
   output logic register_wb_sel,
   output logic vector_wb_sel,
   output logic buffer_register_sel,
   output logic buffer_vector_sel,
   output logic buffer_register,
   output logic buffer_vector,
   output logic scalar_stall
`ifdef WB_ARB_STATS_EN
   ,
   output logic [WB_CNT_W-1:0] buffer_count
`endif
);
   logic stall_reg, stall_vec;

   wb_arb_port u_reg (
      .clk(clk), .rst_n(rst_n), .scalar_req(scalar_reg_req), .vector_req(vector_reg_req),
      .wb_sel(register_wb_sel), .buffer_sel(buffer_register_sel), .capture(buffer_register), .stall(stall_reg)
   );

   wb_arb_port u_vec (
      .clk(clk), .rst_n(rst_n), .scalar_req(scalar_vec_req), .vector_req(vector_vec_req),
      .wb_sel(vector_wb_sel), .buffer_sel(buffer_vector_sel), .capture(buffer_vector), .stall(stall_vec)
   );

   // the scalar pipeline holds its whole writeback if either port is busy draining
   always_comb scalar_stall = stall_reg | stall_vec;

`ifdef WB_ARB_STATS_EN
   // count cycles with any capture, sticking at all-ones
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) buffer_count <= '0;
      else if ((buffer_register | buffer_vector) && buffer_count != '1) buffer_count <= buffer_count + 1'b1;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: vector table, corner sequences and randomized model check for wb_arbiter
module tb_wb_arbiter;
   logic clk = 0, rst_n = 0;
   logic sr = 0, sv = 0, vr = 0, vv = 0;
   logic register_wb_sel, vector_wb_sel, buffer_register_sel, buffer_vector_sel;
   logic buffer_register, buffer_vector, scalar_stall;
`ifdef WB_ARB_STATS_EN
   logic [15:0] buffer_count;
`endif
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   wb_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .scalar_reg_req(sr), .scalar_vec_req(sv), .vector_reg_req(vr), .vector_vec_req(vv),
      .register_wb_sel(register_wb_sel), .vector_wb_sel(vector_wb_sel),
      .buffer_register_sel(buffer_register_sel), .buffer_vector_sel(buffer_vector_sel),
      .buffer_register(buffer_register), .buffer_vector(buffer_vector),
      .scalar_stall(scalar_stall)
`ifdef WB_ARB_STATS_EN
      , .buffer_count(buffer_count)
`endif
   );

   // {reg_wb_sel, vec_wb_sel, buf_reg_sel, buf_vec_sel, buf_reg, buf_vec, stall}
   function automatic logic [6:0] outs();
      return {register_wb_sel, vector_wb_sel, buffer_register_sel, buffer_vector_sel,
              buffer_register, buffer_vector, scalar_stall};
   endfunction

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // drive at posedge+1, compare at the following negedge, return at the next posedge+1
   task automatic step(input logic [3:0] in, input logic [6:0] exp, input string name);
      {sr, sv, vr, vv} = in;
      @(negedge clk);
      check(name, outs(), exp);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0] in;
      logic [6:0] exp;
   } vec_t;

   // reference: pend = vector writebacks waiting in the port buffer; it must drain the cycle after capture
   task automatic model_port(inout int pend, input logic s, input logic v,
                             output logic wb, output logic bs, output logic cap, output logic st);
      wb = 0; bs = 0; cap = 0; st = 0;
      if (pend > 0) begin
         pend--;
         wb = 1; bs = 1; st = s;
         if (v) begin cap = 1; pend++; end
      end else if (s && v) begin
         cap = 1; pend++;
      end else wb = v;
   endtask

   vec_t tbl[$];
   int pend_reg, pend_vec, reg_issued, vec_issued, reg_served, vec_served;
   logic last_stall;

   initial begin
      logic wr, wv, br, bv, cr, cv, str, stv;
      logic [3:0] in;
      // idle after reset, then lone-conflict drain, VEC stall, vector stream, dual-port conflict
      for (int i = 0; i < 5; i++) tbl.push_back('{4'b0000, 7'b0000000});
      tbl.push_back('{4'b1010, 7'b0000100});
      tbl.push_back('{4'b0000, 7'b1010000});
      tbl.push_back('{4'b0000, 7'b0000000});
      tbl.push_back('{4'b0101, 7'b0000010});
      tbl.push_back('{4'b0100, 7'b0101001});
      tbl.push_back('{4'b0100, 7'b0000000});
      tbl.push_back('{4'b0101, 7'b0000010});
      for (int i = 0; i < 3; i++) tbl.push_back('{4'b0001, 7'b0101010});
      tbl.push_back('{4'b0000, 7'b0101000});
      tbl.push_back('{4'b0000, 7'b0000000});
      tbl.push_back('{4'b0010, 7'b1000000});
      tbl.push_back('{4'b0001, 7'b0100000});
      tbl.push_back('{4'b1111, 7'b0000110});
      tbl.push_back('{4'b1010, 7'b1111101});
      tbl.push_back('{4'b0000, 7'b1010000});
      tbl.push_back('{4'b0000, 7'b0000000});

      // outputs held low throughout reset even with every request active
      {sr, sv, vr, vv} = 4'b1111;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", outs(), 7'b0);
`ifdef WB_ARB_STATS_EN
      checks++;
      if (buffer_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", buffer_count); end
`endif
      {sr, sv, vr, vv} = 4'b0000;
      #2 rst_n = 1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) step(tbl[i].in, tbl[i].exp, $sformatf("table[%0d]", i));

      // asynchronous reset while HELD, asserted between edges
      step(4'b1010, 7'b0000100, "seq_conflict_before_reset");
      {sr, sv, vr, vv} = 4'b0010;
      #2 rst_n = 0;
      #1 check("async_reset_outputs", outs(), 7'b0);
      @(negedge clk);
      #2 rst_n = 1;
      @(posedge clk);
      #1;
      step(4'b0010, 7'b1000000, "post_reset_lone_vector");
      step(4'b0000, 7'b0000000, "post_reset_idle");

      // randomized traffic; a stalled scalar writeback is retried unchanged
      pend_reg = 0; pend_vec = 0; last_stall = 0;
      reg_issued = 0; vec_issued = 0; reg_served = 0; vec_served = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!last_stall) begin
            sr = ($urandom_range(0, 2) == 0);
            sv = ($urandom_range(0, 2) == 0);
         end
         vr = ($urandom_range(0, 1) == 0);
         vv = ($urandom_range(0, 1) == 0);
         if (c > 2980) {vr, vv} = 2'b00;
         if (c > 2990) {sr, sv} = 2'b00;
         reg_issued += vr; vec_issued += vv;
         model_port(pend_reg, sr, vr, wr, br, cr, str);
         model_port(pend_vec, sv, vv, wv, bv, cv, stv);
         last_stall = str | stv;
         @(negedge clk);
         check($sformatf("random[%0d]", c), outs(), {wr, wv, br, bv, cr, cv, str | stv});
         reg_served += register_wb_sel; vec_served += vector_wb_sel;
         @(posedge clk);
         #1;
      end
      // every vector writeback is eventually written
      check("no_drop_reg", reg_served[6:0], reg_issued[6:0]);
      checks++;
      if (reg_served != reg_issued) begin errors++; $display("FAIL no_drop_reg_total: got %0d expected %0d", reg_served, reg_issued); end
      checks++;
      if (vec_served != vec_issued) begin errors++; $display("FAIL no_drop_vec_total: got %0d expected %0d", vec_served, vec_issued); end

`ifdef WB_ARB_STATS_EN
      // counter saturates under continuous dual-port conflicts and stays there
      {sr, sv, vr, vv} = 4'b1111;
      repeat (70000) @(posedge clk);
      @(negedge clk);
      checks++;
      if (buffer_count !== 16'hFFFF) begin errors++; $display("FAIL count_saturated: got %h expected ffff", buffer_count); end
      repeat (5) @(posedge clk);
      @(negedge clk);
      checks++;
      if (buffer_count !== 16'hFFFF) begin errors++; $display("FAIL count_hold: got %h expected ffff", buffer_count); end
      {sr, sv, vr, vv} = 4'b0000;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
